mem_arbiter: RTL and testbench

Parametrised round-robin arbiter that lets NUM_CH bus masters (CPU cores, DMA, a bench loader) share one single-port synchronous SRAM. Each channel issues single-word reads or writes through a req/gnt handshake. The granted command is registered onto the SRAM address, data and write-enable lines, and read data is returned with a per-channel valid pulse. It sits between the cpu instances and the sram in the top-level system, replacing the direct point-to-point cpu-to-sram bus.

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter letting NUM_CH masters share one single-port synchronous SRAM.
// Define MEM_ARB_LOCK_EN to let a master lock the arbiter across several commands.
module mem_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH-1:0]        we_i,
  input  logic [NUM_CH*ADDR_W-1:0] addr_i,
  input  logic [NUM_CH*DATA_W-1:0] wdata_i,
  input  logic [NUM_CH-1:0]        lock_i,
  output logic [NUM_CH-1:0]        gnt_o,
  output logic [NUM_CH-1:0]        rvalid_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic                     mem_we_o,
  output logic [DATA_W-1:0]        mem_din_o,
  input  logic [DATA_W-1:0]        mem_dout_i
);

  localparam int                PTR_W    = $clog2(NUM_CH);
  localparam logic [PTR_W:0]    NUM_CH_W = (PTR_W+1)'(NUM_CH);
  localparam logic [PTR_W-1:0]  LAST_CH  = PTR_W'(NUM_CH - 1);

  logic [ADDR_W-1:0] addr_a  [NUM_CH];
  logic [DATA_W-1:0] wdata_a [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign addr_a[g]  = addr_i[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = wdata_i[g*DATA_W +: DATA_W];
  end

  logic [NUM_CH-1:0] gnt_q,      gnt_d;
  logic [NUM_CH-1:0] rd_pend_q,  rd_pend_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q,  mem_din_d;
  logic              mem_we_q,   mem_we_d;
  logic [PTR_W-1:0]  rr_ptr_q,   rr_ptr_d;

  logic [NUM_CH-1:0] elig;
  logic [PTR_W:0]    scan;
  logic              win_vld;
  logic [PTR_W-1:0]  win_idx;

`ifdef MEM_ARB_LOCK_EN
  logic             own_vld_q, own_vld_d;
  logic [PTR_W-1:0] own_q,     own_d;
`else
  logic unused_lock;
  assign unused_lock = ^lock_i;
`endif

  // A channel that is on the bus this cycle is masked so it cannot win twice in a row.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    elig    = req_i & ~gnt_q;
`ifdef MEM_ARB_LOCK_EN
    if (own_vld_q) elig = elig & (NUM_CH'(1) << own_q);
`endif
    win_vld = 1'b0;
    win_idx = '0;
    scan    = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      scan = {1'b0, rr_ptr_q} + (PTR_W+1)'(off);
      if (scan >= NUM_CH_W) scan = scan - NUM_CH_W;
      if (!win_vld && elig[scan[PTR_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = scan[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_d      = '0;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    rr_ptr_d   = rr_ptr_q;
    rd_pend_d  = gnt_q & ~{NUM_CH{mem_we_q}};
`ifdef MEM_ARB_LOCK_EN
    own_vld_d  = own_vld_q;
    own_d      = own_q;
    // An owner that lets its request lapse outside its grant cycle gives up the lock.
    if (own_vld_q && !req_i[own_q] && !gnt_q[own_q]) own_vld_d = 1'b0;
`endif
    if (win_vld) begin
      gnt_d[win_idx] = 1'b1;
      mem_we_d       = we_i[win_idx];
      mem_addr_d     = addr_a[win_idx];
      mem_din_d      = wdata_a[win_idx];
`ifdef MEM_ARB_LOCK_EN
      if (lock_i[win_idx]) begin
        own_vld_d = 1'b1;
        own_d     = win_idx;
      end else begin
        own_vld_d = 1'b0;
      end
      if (!own_vld_q) rr_ptr_d = (win_idx == LAST_CH) ? '0 : win_idx + 1'b1;
`else
      rr_ptr_d = (win_idx == LAST_CH) ? '0 : win_idx + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      gnt_q      <= '0;
      rd_pend_q  <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      rr_ptr_q   <= '0;
`ifdef MEM_ARB_LOCK_EN
      own_vld_q  <= 1'b0;
      own_q      <= '0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so all of them update together.
      gnt_q      <= gnt_d;
      rd_pend_q  <= rd_pend_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      rr_ptr_q   <= rr_ptr_d;
`ifdef MEM_ARB_LOCK_EN
      own_vld_q  <= own_vld_d;
      own_q      <= own_d;
`endif
    end
  end

  assign gnt_o      = gnt_q;
  assign rvalid_o   = rd_pend_q;
  assign rdata_o    = mem_dout_i;
  assign mem_addr_o = mem_addr_q;
  assign mem_we_o   = mem_we_q;
  assign mem_din_o  = mem_din_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-channel command queues drive the masters and
// a read-data scoreboard is filled at grant time and drained on rvalid.
module tb_mem_arbiter;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  typedef struct {
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  logic                     clk;
  logic                     reset_n;
  logic [NUM_CH-1:0]        req, we, lock;
  logic [NUM_CH*ADDR_W-1:0] addr;
  logic [NUM_CH*DATA_W-1:0] wdata;
  logic [NUM_CH-1:0]        gnt, rvalid;
  logic [DATA_W-1:0]        rdata, mem_din, mem_dout;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_we;

  logic [DATA_W-1:0] sram   [4096];
  logic [DATA_W-1:0] golden [4096];

  cmd_t              cmdq [NUM_CH][$];
  logic [DATA_W-1:0] sb[$];
  int                glog[$];
  int                gcyc[$];
  logic [NUM_CH-1:0] rd_prev, gnt_prev;
  int                total, bad, ncyc;

  mem_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk), .reset_ni(reset_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .lock_i(lock), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_din_o(mem_din), .mem_dout_i(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_din;
    mem_dout <= sram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    cmd_t c;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cmdq[i].size() != 0) begin
        c       = cmdq[i][0];
        req[i]  = 1'b1;
        we[i]   = c.we;
        lock[i] = c.lock;
        addr[i*ADDR_W +: ADDR_W]  = c.addr;
        wdata[i*DATA_W +: DATA_W] = c.data;
      end else begin
        req[i]  = 1'b0;
        we[i]   = 1'b0;
        lock[i] = 1'b0;
      end
    end
  endtask

  task automatic push(input int ch, input logic w, input logic l, input int a,
                      input logic [DATA_W-1:0] d);
    cmd_t c;
    c.we   = w;
    c.lock = l;
    c.addr = ADDR_W'(a);
    c.data = d;
    cmdq[ch].push_back(c);
  endtask

  function automatic bit busy();
    for (int i = 0; i < NUM_CH; i++) if (cmdq[i].size() != 0) return 1'b1;
    return rd_prev != 0;
  endfunction

  // One clock: check read return, account for any grant, then update the masters.
  task automatic cycle();
    cmd_t              c;
    int                k;
    logic [NUM_CH-1:0] rd_next;
    @(posedge clk);
    #1;
    ncyc++;
    check("rvalid", rvalid, rd_prev);
    if (rd_prev != 0) begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) check("rdata", rdata, sb.pop_front());
    end
    rd_next = '0;
    if (gnt != 0) begin
      check("gnt_onehot", $onehot(gnt), 1);
      check("gnt_repeat", gnt & gnt_prev, 0);
      k = 0;
      for (int i = NUM_CH - 1; i >= 0; i--) if (gnt[i]) k = i;
      check("gnt_has_req", cmdq[k].size() != 0, 1);
      if (cmdq[k].size() != 0) begin
        c = cmdq[k].pop_front();
        check("mem_addr", mem_addr, c.addr);
        check("mem_we", mem_we, c.we);
        if (c.we) begin
          check("mem_din", mem_din, c.data);
          golden[c.addr] = c.data;
        end else begin
          sb.push_back(golden[c.addr]);
          rd_next = gnt;
        end
      end
      glog.push_back(k);
      gcyc.push_back(ncyc);
    end else begin
      check("idle_we", mem_we, 0);
    end
    gnt_prev = gnt;
    rd_prev  = rd_next;
    drive();
  endtask

  task automatic run(input int max);
    int n = 0;
    while (busy() && n < max) begin
      cycle();
      n++;
    end
    check("drain_timeout", busy(), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sb.delete();
    glog.delete();
    gcyc.delete();
    for (int i = 0; i < NUM_CH; i++) cmdq[i].delete();
    rd_prev  = '0;
    gnt_prev = '0;
    drive();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  initial begin
    int exp_lock [7];
    total = 0; bad = 0; ncyc = 0;
    rd_prev = '0; gnt_prev = '0;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 4096; i++) begin
      sram[i]   = '0;
      golden[i] = '0;
    end
    sram[100] = 16'h0055; golden[100] = 16'h0055;
    for (int i = 200; i < 240; i++) begin
      sram[i]   = DATA_W'($urandom);
      golden[i] = sram[i];
    end

    // Reset state
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #2;
    check("rst_gnt", gnt, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_din", mem_din, 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;

    // Single read by ch0
    push(0, 1'b0, 1'b0, 100, '0);
    drive();
    cycle();
    check("rd_gnt", gnt, 4'b0001);
    check("rd_we", mem_we, 0);
    check("rd_addr", mem_addr, 100);
    cycle();
    check("rd_rvalid", rvalid, 4'b0001);
    check("rd_data", rdata, 16'h0055);
    repeat (2) cycle();

    // Write then read back by ch1
    push(1, 1'b1, 1'b0, 99, 16'h0123);
    push(1, 1'b0, 1'b0, 99, '0);
    drive();
    cycle();
    check("wr_gnt", gnt, 4'b0010);
    check("wr_we", mem_we, 1);
    check("wr_din", mem_din, 16'h0123);
    cycle();
    check("wr_gap_gnt", gnt, 0);
    check("wr_no_rvalid", rvalid, 0);
    cycle();
    check("rb_gnt", gnt, 4'b0010);
    cycle();
    check("rb_rvalid", rvalid, 4'b0010);
    check("rb_data", rdata, 16'h0123);
    run(10);

    // Reset while a read is on the bus: its data must never be returned
    push(0, 1'b0, 1'b0, 100, '0);
    drive();
    cycle();
    check("mr_gnt", gnt, 4'b0001);
    #1 reset_n = 1'b0;
    sb.delete();
    rd_prev  = '0;
    gnt_prev = '0;
    @(posedge clk);
    #1;
    check("mr_rvalid", rvalid, 0);
    check("mr_gnt_rst", gnt, 0);
    check("mr_we", mem_we, 0);
    check("mr_addr", mem_addr, 0);
    check("mr_din", mem_din, 0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    push(0, 1'b0, 1'b0, 100, '0);
    push(3, 1'b0, 1'b0, 99, '0);
    drive();
    cycle();
    check("mr_first", gnt, 4'b0001);
    cycle();
    check("mr_second", gnt, 4'b1000);
    run(10);

    // All channels reading continuously from reset
    do_reset();
    for (int n = 0; n < 3; n++)
      for (int ch = 0; ch < NUM_CH; ch++) push(ch, 1'b0, 1'b0, 200 + ch*8 + n, '0);
    drive();
    run(40);
    check("ct_count", glog.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < glog.size()) begin
        check("ct_order", glog[i], i % NUM_CH);
        check("ct_back_to_back", gcyc[i] - gcyc[0], i);
      end
    end

    // ch2 asks for the lock while ch0 and ch1 compete
    do_reset();
    push(0, 1'b0, 1'b0, 300, '0);
    push(0, 1'b0, 1'b0, 301, '0);
    push(1, 1'b0, 1'b0, 310, '0);
    push(1, 1'b0, 1'b0, 311, '0);
    push(2, 1'b0, 1'b1, 320, '0);
    push(2, 1'b0, 1'b1, 321, '0);
    push(2, 1'b0, 1'b0, 322, '0);
    drive();
    run(40);
`ifdef MEM_ARB_LOCK_EN
    exp_lock = '{0, 1, 2, 2, 2, 0, 1};
`else
    exp_lock = '{0, 1, 2, 0, 1, 2, 2};
`endif
    check("lk_count", glog.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < glog.size()) check("lk_order", glog[i], exp_lock[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
